rv32i_multicycle_ctrl: RTL and testbench
========================================

Name: rv32i_multicycle_ctrl

Overview:
- Parametrised second-generation multicycle RV32I control unit.
- Drives the shared-memory datapath: address mux, IR/PC/regfile/memory enables, ALU operand and op select, result mux.
- Extends the first-generation FSM with LUI, AUIPC, JALR, FENCE-as-NOP, memory ready handshake (wait states), illegal-opcode trap, and an instruction-retire counter.
- Outputs are Moore-decoded from a single state register; fsm_state has no lag.

Parameters:
- HANDSHAKE, 1, 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = memory assumed single-cycle (mem_ready ignored, treated as 1).
- ILLEGAL_TRAP, 1, 1 = unknown opcode enters TRAP, held until reset; 0 = unknown opcode treated as NOP (DECODE->FETCH).
- CNT_W, 32, width of retire_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- opcode  in  7  instr[6:0] from IR; stable from DECODE until the next FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- ir_write  out  1  IR/oldPC load.
- pc_update  out  1  PC load from result bus.
- reg_write  out  1  regfile write.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- branch  out  1  conditional PC load if ALU zero (datapath qualifies).
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4.
- alu_op  out  3  000 = add, 001 = branch compare, 010 = R-type funct decode, 011 = I-type funct decode.
- result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result.
- illegal_instr  out  1  high in TRAP.
- fsm_state  out  4  current state encoding.
- retire_count  out  CNT_W  retired-instruction count.

Behaviour:
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, LUI 4, AUIPC 5, JAL 6, JALR_ADR 7, JALR_LINK 8, BRANCH 9, MEMADR 10, MEMREAD 11, MEMWRITE 12, MEMWB 13, ALUWB 14, TRAP 15.
- Any output not listed for a state is 0.
- Reset:
  - state <= FETCH; retire_count <= 0.
  - In a cycle with reset = 1, ir_write, pc_update, reg_write, mem_read, mem_write and branch are forced 0.
  - Reset takes priority over all transitions, including from TRAP and mid wait-state.
- FETCH: adr_src = 0, mem_read = 1, a = 00, b = 10, op = 000, result_src = 10.
  - ir_write = pc_update = mem_ready (the only ready-qualified outputs).
  - mem_ready -> DECODE, else stay in FETCH.
- DECODE: a = 01, b = 01, op = 000 (branch/JAL target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - 1100011 -> BRANCH
  - 0000011 or 0100011 -> MEMADR
  - 0001111 -> FETCH
  - other -> TRAP (ILLEGAL_TRAP = 1) or FETCH (ILLEGAL_TRAP = 0)
- EXEC_R: a = 10, b = 00, op = 010 -> ALUWB.
- EXEC_I: a = 10, b = 01, op = 011 -> ALUWB.
- LUI: a = 11, b = 01, op = 000 -> ALUWB.
- AUIPC: a = 01, b = 01, op = 000 -> ALUWB.
- JAL: a = 01, b = 10, op = 000, result_src = 00, pc_update = 1 -> ALUWB.
- JALR_ADR: a = 10, b = 01, op = 000 -> JALR_LINK.
- JALR_LINK: a = 01, b = 10, op = 000, result_src = 00, pc_update = 1 -> ALUWB. Target bit 0 is cleared in the datapath.
- BRANCH: a = 10, b = 00, op = 001, result_src = 00, branch = 1 -> FETCH.
- MEMADR: a = 10, b = 01, op = 000. opcode 0000011 -> MEMREAD, else MEMWRITE.
- MEMREAD: adr_src = 1, mem_read = 1, result_src = 00. mem_ready -> MEMWB, else stay.
- MEMWRITE: adr_src = 1, mem_write = 1, result_src = 00. mem_ready -> FETCH, else stay. mem_write stays high for every wait cycle.
- MEMWB: result_src = 01, reg_write = 1 -> FETCH.
- ALUWB: result_src = 00, reg_write = 1 -> FETCH.
- TRAP: illegal_instr = 1, all enables 0, self-loop until reset.
- Retire counter:
  - Increments by 1 in every cycle where the next state is FETCH and the current state is not FETCH or TRAP.
  - Wraps modulo 2^CNT_W.
  - Illegal opcodes with ILLEGAL_TRAP = 0 count as retired (NOP).
- Latencies in cycles, at 0 wait states: R/I/LUI/AUIPC/JAL 4, JALR 5, BRANCH 3, load 5, store 4, FENCE 2.

Test Plan:
- Reset, then add (0110011), mem_ready = 1 -> fsm_state 0,1,2,14,0; reg_write = 1 only in state 14; retire_count = 1.
- Load with mem_ready low 3 cycles in MEMREAD -> fsm_state 0,1,10,11,11,11,11,13,0; mem_read held high 4 cycles in state 11; adr_src = 1.
- JALR (1100111) -> states 0,1,7,8,14,0; pc_update = 1 in state 8 with result_src = 00; reg_write = 1 in state 14.
- Opcode 1111111, ILLEGAL_TRAP = 1 -> state 15, illegal_instr = 1, retire_count unchanged; reset -> state 0. Same opcode with ILLEGAL_TRAP = 0 -> 1 -> 0, count +1.
- FETCH with mem_ready = 0 for 2 cycles -> ir_write = pc_update = 0 for those cycles, 1 only in the ready cycle; reset asserted in MEMWRITE wait -> mem_write = 0 that cycle, state 0 next.
- CNT_W = 4, 17 branch instructions -> retire_count = 1 (wrap).

Source files
------------

// File: rtl/rv32i_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_multicycle_ctrl
//  Description : Second-generation multicycle RV32I control unit. A single
//                state register drives Moore-decoded datapath controls, with
//                memory wait states, an illegal-opcode trap and a retire
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_multicycle_ctrl #(
  parameter int HANDSHAKE    = 1,
  parameter int ILLEGAL_TRAP = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_update,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal_instr,
  output logic [3:0]       fsm_state,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [3:0] c_FETCH     = 4'd0;
  localparam logic [3:0] c_DECODE    = 4'd1;
  localparam logic [3:0] c_EXEC_R    = 4'd2;
  localparam logic [3:0] c_EXEC_I    = 4'd3;
  localparam logic [3:0] c_LUI       = 4'd4;
  localparam logic [3:0] c_AUIPC     = 4'd5;
  localparam logic [3:0] c_JAL       = 4'd6;
  localparam logic [3:0] c_JALR_ADR  = 4'd7;
  localparam logic [3:0] c_JALR_LINK = 4'd8;
  localparam logic [3:0] c_BRANCH    = 4'd9;
  localparam logic [3:0] c_MEMADR    = 4'd10;
  localparam logic [3:0] c_MEMREAD   = 4'd11;
  localparam logic [3:0] c_MEMWRITE  = 4'd12;
  localparam logic [3:0] c_MEMWB     = 4'd13;
  localparam logic [3:0] c_ALUWB     = 4'd14;
  localparam logic [3:0] c_TRAP      = 4'd15;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_retire;
  logic             w_ready;
  logic             w_retire;

  // Enables before the reset override
  logic w_ir_write, w_pc_update, w_reg_write, w_mem_read, w_mem_write, w_branch;

  // Without the handshake, memory always completes in one cycle
  assign w_ready = (HANDSHAKE != 0) ? mem_ready : 1'b1;

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_FETCH:     w_next = w_ready ? c_DECODE : c_FETCH;
      c_DECODE: begin
        case (opcode)
          c_OP_R:      w_next = c_EXEC_R;
          c_OP_I:      w_next = c_EXEC_I;
          c_OP_LUI:    w_next = c_LUI;
          c_OP_AUIPC:  w_next = c_AUIPC;
          c_OP_JAL:    w_next = c_JAL;
          c_OP_JALR:   w_next = c_JALR_ADR;
          c_OP_BRANCH: w_next = c_BRANCH;
          c_OP_LOAD,
          c_OP_STORE:  w_next = c_MEMADR;
          c_OP_FENCE:  w_next = c_FETCH;
          default:     w_next = (ILLEGAL_TRAP != 0) ? c_TRAP : c_FETCH;
        endcase
      end
      c_EXEC_R,
      c_EXEC_I,
      c_LUI,
      c_AUIPC,
      c_JAL:       w_next = c_ALUWB;
      c_JALR_ADR:  w_next = c_JALR_LINK;
      c_JALR_LINK: w_next = c_ALUWB;
      c_BRANCH:    w_next = c_FETCH;
      c_MEMADR:    w_next = (opcode == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
      c_MEMREAD:   w_next = w_ready ? c_MEMWB : c_MEMREAD;
      c_MEMWRITE:  w_next = w_ready ? c_FETCH : c_MEMWRITE;
      c_MEMWB,
      c_ALUWB:     w_next = c_FETCH;
      c_TRAP:      w_next = c_TRAP;
      default:     w_next = c_FETCH;
    endcase
  end

  // An instruction retires when it hands control back to FETCH
  assign w_retire = (w_next == c_FETCH) && (r_state != c_FETCH) && (r_state != c_TRAP);

  // State register and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_FETCH;
      r_retire <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retire <= r_retire + CNT_W'(1);
    end
  end

  // Moore output decode; only the FETCH load enables look at mem_ready
  always_comb begin
    adr_src       = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_update   = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_branch      = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    result_src    = 2'b00;
    illegal_instr = 1'b0;
    case (r_state)
      c_FETCH: begin
        w_mem_read  = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        w_ir_write  = w_ready;
        w_pc_update = w_ready;
      end
      c_DECODE:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      c_EXEC_R:    begin alu_src_a = 2'b10; alu_op = 3'b010; end
      c_EXEC_I:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 3'b011; end
      c_LUI:       begin alu_src_a = 2'b11; alu_src_b = 2'b01; end
      c_AUIPC:     begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      c_JAL,
      c_JALR_LINK: begin alu_src_a = 2'b01; alu_src_b = 2'b10; w_pc_update = 1'b1; end
      c_JALR_ADR,
      c_MEMADR:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      c_BRANCH:    begin alu_src_a = 2'b10; alu_op = 3'b001; w_branch = 1'b1; end
      c_MEMREAD:   begin adr_src = 1'b1; w_mem_read = 1'b1; end
      c_MEMWRITE:  begin adr_src = 1'b1; w_mem_write = 1'b1; end
      c_MEMWB:     begin result_src = 2'b01; w_reg_write = 1'b1; end
      c_ALUWB:     w_reg_write = 1'b1;
      c_TRAP:      illegal_instr = 1'b1;
      default:     ;
    endcase
  end

  // Reset suppresses every side-effecting enable in the same cycle
  assign ir_write     = w_ir_write  & ~reset;
  assign pc_update    = w_pc_update & ~reset;
  assign reg_write    = w_reg_write & ~reset;
  assign mem_read     = w_mem_read  & ~reset;
  assign mem_write    = w_mem_write & ~reset;
  assign branch       = w_branch    & ~reset;
  assign fsm_state    = r_state;
  assign retire_count = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_multicycle_ctrl
//  Description : Self-checking bench for rv32i_multicycle_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_multicycle_ctrl;

  // Output bundle order:
  // {adr_src, ir_write, pc_update, reg_write, mem_read, mem_write, branch,
  //  alu_src_a[1:0], alu_src_b[1:0], alu_op[2:0], result_src[1:0], illegal_instr}
  localparam logic [16:0] O_FETCH_R     = 17'b0110100_00_10_000_10_0;
  localparam logic [16:0] O_FETCH_W     = 17'b0000100_00_10_000_10_0;
  localparam logic [16:0] O_FETCH_RST   = 17'b0000000_00_10_000_10_0;
  localparam logic [16:0] O_DECODE      = 17'b0000000_01_01_000_00_0;
  localparam logic [16:0] O_EXEC_R      = 17'b0000000_10_00_010_00_0;
  localparam logic [16:0] O_EXEC_I      = 17'b0000000_10_01_011_00_0;
  localparam logic [16:0] O_LUI         = 17'b0000000_11_01_000_00_0;
  localparam logic [16:0] O_AUIPC       = 17'b0000000_01_01_000_00_0;
  localparam logic [16:0] O_JAL         = 17'b0010000_01_10_000_00_0;
  localparam logic [16:0] O_JALR_ADR    = 17'b0000000_10_01_000_00_0;
  localparam logic [16:0] O_JALR_LINK   = 17'b0010000_01_10_000_00_0;
  localparam logic [16:0] O_BRANCH      = 17'b0000001_10_00_001_00_0;
  localparam logic [16:0] O_MEMADR      = 17'b0000000_10_01_000_00_0;
  localparam logic [16:0] O_MEMREAD     = 17'b1000100_00_00_000_00_0;
  localparam logic [16:0] O_MEMWRITE    = 17'b1000010_00_00_000_00_0;
  localparam logic [16:0] O_MEMWRITE_RS = 17'b1000000_00_00_000_00_0;
  localparam logic [16:0] O_MEMWB       = 17'b0001000_00_00_000_01_0;
  localparam logic [16:0] O_ALUWB       = 17'b0001000_00_00_000_00_0;
  localparam logic [16:0] O_TRAP        = 17'b0000000_00_00_000_00_1;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_FENCE = 7'b0001111, OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- per-instance signals ----------------
  logic        rst0 = 1'b1, rdy0 = 1'b1;
  logic [6:0]  op0 = 7'd0;
  logic        as0, irw0, pcu0, rw0, mr0, mw0, br0, ill0;
  logic [1:0]  sa0, sb0, rs0;
  logic [2:0]  aop0;
  logic [3:0]  st0;
  logic [31:0] cnt0;
  logic [16:0] outs0;
  assign outs0 = {as0, irw0, pcu0, rw0, mr0, mw0, br0, sa0, sb0, aop0, rs0, ill0};

  logic        rst1 = 1'b1, rdy1 = 1'b1;
  logic [6:0]  op1 = 7'd0;
  logic        as1, irw1, pcu1, rw1, mr1, mw1, br1, ill1;
  logic [1:0]  sa1, sb1, rs1;
  logic [2:0]  aop1;
  logic [3:0]  st1;
  logic [31:0] cnt1;

  logic        rst2 = 1'b1, rdy2 = 1'b1;
  logic [6:0]  op2 = 7'd0;
  logic        as2, irw2, pcu2, rw2, mr2, mw2, br2, ill2;
  logic [1:0]  sa2, sb2, rs2;
  logic [2:0]  aop2;
  logic [3:0]  st2;
  logic [3:0]  cnt2;

  logic        rst3 = 1'b1, rdy3 = 1'b0;
  logic [6:0]  op3 = 7'd0;
  logic        as3, irw3, pcu3, rw3, mr3, mw3, br3, ill3;
  logic [1:0]  sa3, sb3, rs3;
  logic [2:0]  aop3;
  logic [3:0]  st3;
  logic [31:0] cnt3;

  rv32i_multicycle_ctrl dut0 (
    .clk(clk), .reset(rst0), .opcode(op0), .mem_ready(rdy0),
    .adr_src(as0), .ir_write(irw0), .pc_update(pcu0), .reg_write(rw0),
    .mem_read(mr0), .mem_write(mw0), .branch(br0), .alu_src_a(sa0),
    .alu_src_b(sb0), .alu_op(aop0), .result_src(rs0), .illegal_instr(ill0),
    .fsm_state(st0), .retire_count(cnt0));

  rv32i_multicycle_ctrl #(.ILLEGAL_TRAP(0)) dut1 (
    .clk(clk), .reset(rst1), .opcode(op1), .mem_ready(rdy1),
    .adr_src(as1), .ir_write(irw1), .pc_update(pcu1), .reg_write(rw1),
    .mem_read(mr1), .mem_write(mw1), .branch(br1), .alu_src_a(sa1),
    .alu_src_b(sb1), .alu_op(aop1), .result_src(rs1), .illegal_instr(ill1),
    .fsm_state(st1), .retire_count(cnt1));

  rv32i_multicycle_ctrl #(.CNT_W(4)) dut2 (
    .clk(clk), .reset(rst2), .opcode(op2), .mem_ready(rdy2),
    .adr_src(as2), .ir_write(irw2), .pc_update(pcu2), .reg_write(rw2),
    .mem_read(mr2), .mem_write(mw2), .branch(br2), .alu_src_a(sa2),
    .alu_src_b(sb2), .alu_op(aop2), .result_src(rs2), .illegal_instr(ill2),
    .fsm_state(st2), .retire_count(cnt2));

  rv32i_multicycle_ctrl #(.HANDSHAKE(0)) dut3 (
    .clk(clk), .reset(rst3), .opcode(op3), .mem_ready(rdy3),
    .adr_src(as3), .ir_write(irw3), .pc_update(pcu3), .reg_write(rw3),
    .mem_read(mr3), .mem_write(mw3), .branch(br3), .alu_src_a(sa3),
    .alu_src_b(sb3), .alu_op(aop3), .result_src(rs3), .illegal_instr(ill3),
    .fsm_state(st3), .retire_count(cnt3));

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] outs;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst, input logic [6:0] op, input logic rdy,
                   input logic [3:0] st, input logic [16:0] outs, input int cnt);
    vec_t t;
    t.rst = rst; t.op = op; t.rdy = rdy; t.st = st; t.outs = outs; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Reset, then add
    v(1, OP_R, 1,  0, O_FETCH_RST, 0);
    v(0, OP_R, 1,  0, O_FETCH_R,   0);
    v(0, OP_R, 1,  1, O_DECODE,    0);
    v(0, OP_R, 1,  2, O_EXEC_R,    0);
    v(0, OP_R, 1, 14, O_ALUWB,     0);
    // Load with three wait cycles in MEMREAD
    v(0, OP_LD, 1,  0, O_FETCH_R, 1);
    v(0, OP_LD, 1,  1, O_DECODE,  1);
    v(0, OP_LD, 1, 10, O_MEMADR,  1);
    v(0, OP_LD, 0, 11, O_MEMREAD, 1);
    v(0, OP_LD, 0, 11, O_MEMREAD, 1);
    v(0, OP_LD, 0, 11, O_MEMREAD, 1);
    v(0, OP_LD, 1, 11, O_MEMREAD, 1);
    v(0, OP_LD, 1, 13, O_MEMWB,   1);
    // JALR
    v(0, OP_JALR, 1,  0, O_FETCH_R,   2);
    v(0, OP_JALR, 1,  1, O_DECODE,    2);
    v(0, OP_JALR, 1,  7, O_JALR_ADR,  2);
    v(0, OP_JALR, 1,  8, O_JALR_LINK, 2);
    v(0, OP_JALR, 1, 14, O_ALUWB,     2);
    // FETCH waits, store waits, reset inside the store wait
    v(0, OP_ST, 0,  0, O_FETCH_W,     3);
    v(0, OP_ST, 0,  0, O_FETCH_W,     3);
    v(0, OP_ST, 1,  0, O_FETCH_R,     3);
    v(0, OP_ST, 1,  1, O_DECODE,      3);
    v(0, OP_ST, 1, 10, O_MEMADR,      3);
    v(0, OP_ST, 0, 12, O_MEMWRITE,    3);
    v(1, OP_ST, 0, 12, O_MEMWRITE_RS, 3);
    // Illegal opcode traps and holds until reset
    v(0, OP_BAD, 1,  0, O_FETCH_R, 0);
    v(0, OP_BAD, 1,  1, O_DECODE,  0);
    v(0, OP_BAD, 1, 15, O_TRAP,    0);
    v(0, OP_BAD, 1, 15, O_TRAP,    0);
    v(1, OP_BAD, 1, 15, O_TRAP,    0);
    // Branch, FENCE, LUI, JAL, I-type, AUIPC
    v(0, OP_BR, 1,  0, O_FETCH_R, 0);
    v(0, OP_BR, 1,  1, O_DECODE,  0);
    v(0, OP_BR, 1,  9, O_BRANCH,  0);
    v(0, OP_FENCE, 1, 0, O_FETCH_R, 1);
    v(0, OP_FENCE, 1, 1, O_DECODE,  1);
    v(0, OP_LUI, 1,  0, O_FETCH_R, 2);
    v(0, OP_LUI, 1,  1, O_DECODE,  2);
    v(0, OP_LUI, 1,  4, O_LUI,     2);
    v(0, OP_LUI, 1, 14, O_ALUWB,   2);
    v(0, OP_JAL, 1,  0, O_FETCH_R, 3);
    v(0, OP_JAL, 1,  1, O_DECODE,  3);
    v(0, OP_JAL, 1,  6, O_JAL,     3);
    v(0, OP_JAL, 1, 14, O_ALUWB,   3);
    v(0, OP_I, 1,  0, O_FETCH_R, 4);
    v(0, OP_I, 1,  1, O_DECODE,  4);
    v(0, OP_I, 1,  3, O_EXEC_I,  4);
    v(0, OP_I, 1, 14, O_ALUWB,   4);
    v(0, OP_AUIPC, 1,  0, O_FETCH_R, 5);
    v(0, OP_AUIPC, 1,  1, O_DECODE,  5);
    v(0, OP_AUIPC, 1,  5, O_AUIPC,   5);
    v(0, OP_AUIPC, 1, 14, O_ALUWB,   5);
    v(0, OP_AUIPC, 1,  0, O_FETCH_R, 6);

    // Initial reset of every instance
    repeat (2) @(posedge clk);

    // Table-driven run on the default instance
    foreach (vecs[i]) begin
      @(negedge clk);
      rst0 = vecs[i].rst; op0 = vecs[i].op; rdy0 = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d state", i), {28'd0, st0}, {28'd0, vecs[i].st});
      check($sformatf("vec%0d outs", i), {15'd0, outs0}, {15'd0, vecs[i].outs});
      check($sformatf("vec%0d count", i), cnt0, vecs[i].cnt);
    end

    // ILLEGAL_TRAP = 0: unknown opcode retires as a NOP
    @(negedge clk); rst1 = 1'b0; op1 = OP_BAD; #1;
    check("nop fetch state", {28'd0, st1}, 32'd0);
    @(negedge clk); #1;
    check("nop decode state", {28'd0, st1}, 32'd1);
    @(negedge clk); #1;
    check("nop back to fetch", {28'd0, st1}, 32'd0);
    check("nop illegal_instr", {31'd0, ill1}, 32'd0);
    check("nop retired", cnt1, 32'd1);

    // HANDSHAKE = 0: mem_ready held low is ignored
    @(negedge clk); rst3 = 1'b0; op3 = OP_LD; rdy3 = 1'b0; #1;
    check("nohs fetch ir_write", {31'd0, irw3}, 32'd1);
    @(negedge clk); #1; check("nohs decode", {28'd0, st3}, 32'd1);
    @(negedge clk); #1; check("nohs memadr", {28'd0, st3}, 32'd10);
    @(negedge clk); #1; check("nohs memread", {28'd0, st3}, 32'd11);
    @(negedge clk); #1; check("nohs memwb", {28'd0, st3}, 32'd13);
    @(negedge clk); #1; check("nohs fetch", {28'd0, st3}, 32'd0);
    check("nohs count", cnt3, 32'd1);

    // CNT_W = 4: 17 branches wrap the counter to 1
    @(negedge clk); rst2 = 1'b0; op2 = OP_BR; rdy2 = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      check($sformatf("wrap br%0d fetch", k), {28'd0, st2}, 32'd0);
      check($sformatf("wrap br%0d count", k), {28'd0, cnt2}, k % 16);
      repeat (3) @(negedge clk);
    end
    #1;
    check("wrap final count", {28'd0, cnt2}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
